// File: rtl/memory_access_responder.sv
// Data-memory responder: multi-cycle access to async SRAM or UART.
// Stalls the pipeline with busy until a one-cycle done pulse.
module memory_access_responder #(
  parameter int          READ_WAIT_CYCLES   = 1,
  parameter int          WRITE_PULSE_CYCLES = 1,
  parameter logic [15:0] UART_DATA_ADDR     = 16'hBF00,
  parameter logic [15:0] UART_STAT_ADDR     = 16'hBF01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  memory_control,
  input  logic [15:0] memory_address,
  input  logic [15:0] write_data,
  output logic [15:0] read_data,
  output logic        done,
  output logic        busy,
  output logic [17:0] ram_addr,
  input  logic [15:0] ram_dq_in,
  output logic [15:0] ram_dq_out,
  output logic        ram_dq_oe,
  output logic        ram_ce_n,
  output logic        ram_oe_n,
  output logic        ram_we_n,
  input  logic        uart_rx_valid,
  input  logic [7:0]  uart_rx_data,
  output logic        uart_rx_ack,
  output logic        uart_tx_valid,
  output logic [7:0]  uart_tx_data,
  input  logic        uart_tx_ready
);

  typedef enum logic [2:0] {
    IDLE,
    R_ACCESS,
    W_SETUP,
    W_PULSE,
    W_HOLD,
    U_TX,
    DONE
  } state_t;

  localparam logic [7:0] RD_LAST = 8'(READ_WAIT_CYCLES);
  localparam logic [7:0] WR_LAST = 8'(WRITE_PULSE_CYCLES - 1);

  state_t      state;
  state_t      state_next;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [7:0]  cnt;
  logic        req_read;
  logic        req_write;
  logic        at_data;
  logic        at_stat;
  logic        accept;
  logic        cnt_clr;
  logic        load_rd;
  logic [15:0] rd_next;

  assign req_read  = (memory_control == 2'b01);
  assign req_write = (memory_control == 2'b10);
  assign at_data   = (memory_address == UART_DATA_ADDR);
  assign at_stat   = (memory_address == UART_STAT_ADDR);

  assign ram_addr     = {2'b00, addr_q};
  assign ram_dq_out   = wdata_q;
  assign uart_tx_data = wdata_q[7:0];

  assign busy = ((req_read || req_write) && state != DONE)
             || (state != IDLE && state != DONE);

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state, strobes and datapath controls.
  always_comb begin
    state_next    = state;
    accept        = 1'b0;
    cnt_clr       = 1'b0;
    load_rd       = 1'b0;
    rd_next       = ram_dq_in;
    ram_ce_n      = 1'b1;
    ram_oe_n      = 1'b1;
    ram_we_n      = 1'b1;
    ram_dq_oe     = 1'b0;
    done          = 1'b0;
    uart_rx_ack   = 1'b0;
    uart_tx_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_read) begin
          accept  = 1'b1;
          cnt_clr = 1'b1;
          if (at_data) begin
            load_rd     = 1'b1;
            rd_next     = uart_rx_valid ? {8'h00, uart_rx_data} : 16'h0000;
            uart_rx_ack = uart_rx_valid;
            state_next  = DONE;
          end else if (at_stat) begin
            load_rd    = 1'b1;
            rd_next    = {14'b0, uart_rx_valid, uart_tx_ready};
            state_next = DONE;
          end else begin
            state_next = R_ACCESS;
          end
        end else if (req_write) begin
          accept  = 1'b1;
          cnt_clr = 1'b1;
          if (at_data)      state_next = U_TX;
          else if (at_stat) state_next = DONE;
          else              state_next = W_SETUP;
        end
      end
      R_ACCESS: begin
        ram_ce_n = 1'b0;
        ram_oe_n = 1'b0;
        if (cnt == RD_LAST) begin
          load_rd    = 1'b1;
          state_next = DONE;
        end
      end
      W_SETUP: begin
        ram_ce_n   = 1'b0;
        ram_dq_oe  = 1'b1;
        cnt_clr    = 1'b1;
        state_next = W_PULSE;
      end
      W_PULSE: begin
        ram_ce_n  = 1'b0;
        ram_we_n  = 1'b0;
        ram_dq_oe = 1'b1;
        if (cnt == WR_LAST) state_next = W_HOLD;
      end
      W_HOLD: begin
        ram_ce_n   = 1'b0;
        ram_dq_oe  = 1'b1;
        state_next = DONE;
      end
      U_TX: begin
        uart_tx_valid = 1'b1;
        if (uart_tx_ready) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latch, wait counter and load result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt       <= '0;
      read_data <= '0;
    end else begin
      if (accept) begin
        addr_q  <= memory_address;
        wdata_q <= write_data;
      end
      cnt <= cnt_clr ? 8'd0 : cnt + 8'd1;
      if (load_rd) read_data <= rd_next;
    end
  end

endmodule

// File: tb/tb_memory_access_responder.sv
// Directed bench for memory_access_responder.
// Includes a small async SRAM model on the board pins.
module tb_memory_access_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mc;
  logic [15:0] addr;
  logic [15:0] wd;
  logic [15:0] read_data;
  logic        done;
  logic        busy;
  logic [17:0] ram_addr;
  logic [15:0] ram_dq_in;
  logic [15:0] ram_dq_out;
  logic        ram_dq_oe;
  logic        ram_ce_n;
  logic        ram_oe_n;
  logic        ram_we_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ack;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  logic [15:0] mem [0:255];

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  memory_access_responder dut (
    .clk            (clk),
    .rst            (rst),
    .memory_control (mc),
    .memory_address (addr),
    .write_data     (wd),
    .read_data      (read_data),
    .done           (done),
    .busy           (busy),
    .ram_addr       (ram_addr),
    .ram_dq_in      (ram_dq_in),
    .ram_dq_out     (ram_dq_out),
    .ram_dq_oe      (ram_dq_oe),
    .ram_ce_n       (ram_ce_n),
    .ram_oe_n       (ram_oe_n),
    .ram_we_n       (ram_we_n),
    .uart_rx_valid  (rx_valid),
    .uart_rx_data   (rx_data),
    .uart_rx_ack    (rx_ack),
    .uart_tx_valid  (tx_valid),
    .uart_tx_data   (tx_data),
    .uart_tx_ready  (tx_ready)
  );

  // SRAM model: write on edge with we low, read while ce/oe low.
  always @(posedge clk) begin
    if (!ram_ce_n && !ram_we_n && ram_dq_oe)
      mem[ram_addr[7:0]] <= ram_dq_out;
  end

  always_comb begin
    ram_dq_in = 16'hDEAD;
    if (!ram_ce_n && !ram_oe_n) ram_dq_in = mem[ram_addr[7:0]];
  end

  // Drives one request and observes it; the caller checks.
  task automatic run_req(
    input  logic [1:0]  ctl,
    input  logic [15:0] a,
    input  logic [15:0] d,
    output int          done_cyc,
    output logic [15:0] rd,
    output int          ack_n,
    output int          ack_c0
  );
    done_cyc = -1;
    rd       = 16'hFFFF;
    ack_n    = 0;
    ack_c0   = 0;
    @(posedge clk); #1;
    mc = ctl; addr = a; wd = d;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rx_ack) ack_n++;
      if (rx_ack && c == 0) ack_c0 = 1;
      if (done && done_cyc < 0) begin
        done_cyc = c;
        rd = read_data;
      end
      @(posedge clk); #1;
      if (done_cyc >= 0) mc = 2'b00;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mc = 2'b00; addr = '0; wd = '0;
    rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({read_data, done, busy} !== 18'h0) begin
      $display("FAIL reset_core rd=%h done=%b busy=%b req=0",
               read_data, done, busy);
    end else pass_cnt++;
    total++;
    if ({ram_addr, ram_dq_out, ram_dq_oe} !== 35'h0) begin
      $display("FAIL reset_ram addr=%h dq=%h oe=%b req=0",
               ram_addr, ram_dq_out, ram_dq_oe);
    end else pass_cnt++;
    total++;
    if ({ram_ce_n, ram_oe_n, ram_we_n} !== 3'b111) begin
      $display("FAIL reset_strobes got=%b req=111",
               {ram_ce_n, ram_oe_n, ram_we_n});
    end else pass_cnt++;
    total++;
    if ({rx_ack, tx_valid, tx_data} !== 10'h0) begin
      $display("FAIL reset_uart got=%h req=0",
               {rx_ack, tx_valid, tx_data});
    end else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_sram_write();
    int          done_cyc = -1;
    int          we_low = 0;
    logic [6:0]  busy_m = '0;
    bit          conflict = 1'b0;
    logic [17:0] pa = '0;
    logic [15:0] pd = '0;
    @(posedge clk); #1;
    mc = 2'b10; addr = 16'h0040; wd = 16'h1234;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      busy_m[c] = busy;
      if (!ram_we_n) begin
        we_low++;
        pa = ram_addr;
        pd = ram_dq_out;
      end
      if (!ram_oe_n && ram_dq_oe) conflict = 1'b1;
      if (done && done_cyc < 0) done_cyc = c;
      @(posedge clk); #1;
      if (done_cyc >= 0) mc = 2'b00;
    end
    total++;
    if (we_low != 1) begin
      $display("FAIL wr_we_width got=%0d req=1", we_low);
    end else pass_cnt++;
    total++;
    if (done_cyc != 4) begin
      $display("FAIL wr_done_cycle got=%0d req=4", done_cyc);
    end else pass_cnt++;
    total++;
    if (busy_m !== 7'b0001111) begin
      $display("FAIL wr_busy got=%b req=0001111", busy_m);
    end else pass_cnt++;
    total++;
    if (conflict) begin
      $display("FAIL wr_bus_conflict got=1 req=0");
    end else pass_cnt++;
    total++;
    if ({pa, pd} !== {18'h00040, 16'h1234}) begin
      $display("FAIL wr_pins addr=%h dq=%h req=00040/1234", pa, pd);
    end else pass_cnt++;
    total++;
    if (mem[8'h40] !== 16'h1234) begin
      $display("FAIL wr_mem got=%h req=1234", mem[8'h40]);
    end else pass_cnt++;
  endtask

  task automatic test_sram_read();
    int          done_cyc = -1;
    int          oe_low = 0;
    bit          dq_oe_seen = 1'b0;
    logic [15:0] rd = '0;
    @(posedge clk); #1;
    mc = 2'b01; addr = 16'h0040;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (!ram_oe_n && !ram_ce_n) oe_low++;
      if (ram_dq_oe) dq_oe_seen = 1'b1;
      if (done && done_cyc < 0) begin
        done_cyc = c;
        rd = read_data;
      end
      @(posedge clk); #1;
      if (done_cyc >= 0) mc = 2'b00;
    end
    total++;
    if (done_cyc != 3) begin
      $display("FAIL rd_done_cycle got=%0d req=3", done_cyc);
    end else pass_cnt++;
    total++;
    if (rd !== 16'h1234) begin
      $display("FAIL rd_data got=%h req=1234", rd);
    end else pass_cnt++;
    total++;
    if (oe_low != 2) begin
      $display("FAIL rd_oe_width got=%0d req=2", oe_low);
    end else pass_cnt++;
    total++;
    if (dq_oe_seen) begin
      $display("FAIL rd_dq_oe got=1 req=0");
    end else pass_cnt++;
    total++;
    if (read_data !== 16'h1234) begin
      $display("FAIL rd_hold got=%h req=1234", read_data);
    end else pass_cnt++;
  endtask

  task automatic test_uart_read();
    int          dc;
    int          an;
    int          a0;
    logic [15:0] rd;
    rx_valid = 1'b1; tx_ready = 1'b0; rx_data = 8'h41;
    run_req(2'b01, 16'hBF01, 16'h0, dc, rd, an, a0);
    total++;
    if (dc != 1 || rd !== 16'h0002 || an != 0) begin
      $display("FAIL uart_stat dc=%0d rd=%h ack=%0d req=1/0002/0",
               dc, rd, an);
    end else pass_cnt++;
    run_req(2'b01, 16'hBF00, 16'h0, dc, rd, an, a0);
    total++;
    if (dc != 1 || rd !== 16'h0041) begin
      $display("FAIL uart_rx dc=%0d rd=%h req=1/0041", dc, rd);
    end else pass_cnt++;
    total++;
    if (an != 1 || a0 != 1) begin
      $display("FAIL uart_rx_ack n=%0d c0=%0d req=1/1", an, a0);
    end else pass_cnt++;
    rx_valid = 1'b0;
    run_req(2'b01, 16'hBF00, 16'h0, dc, rd, an, a0);
    total++;
    if (dc != 1 || rd !== 16'h0000 || an != 0) begin
      $display("FAIL uart_rx_empty dc=%0d rd=%h ack=%0d req=1/0000/0",
               dc, rd, an);
    end else pass_cnt++;
  endtask

  task automatic test_uart_write();
    int         done_cyc = -1;
    logic [9:0] val_m = '0;
    logic [9:0] busy_m = '0;
    logic [7:0] td = '0;
    tx_ready = 1'b0;
    @(posedge clk); #1;
    mc = 2'b10; addr = 16'hBF00; wd = 16'h0055;
    for (int c = 0; c < 10; c++) begin
      if (c == 6) tx_ready = 1'b1;
      @(negedge clk);
      val_m[c]  = tx_valid;
      busy_m[c] = busy;
      if (c == 1) td = tx_data;
      if (done && done_cyc < 0) done_cyc = c;
      @(posedge clk); #1;
      if (done_cyc >= 0) begin
        mc = 2'b00;
        tx_ready = 1'b0;
      end
    end
    total++;
    if (val_m !== 10'b0001111110) begin
      $display("FAIL utx_valid got=%b req=0001111110", val_m);
    end else pass_cnt++;
    total++;
    if (busy_m !== 10'b0001111111) begin
      $display("FAIL utx_busy got=%b req=0001111111", busy_m);
    end else pass_cnt++;
    total++;
    if (done_cyc != 7 || td !== 8'h55) begin
      $display("FAIL utx_done dc=%0d data=%h req=7/55", done_cyc, td);
    end else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int  done_n = 0;
    @(posedge clk); #1;
    mc = 2'b10; addr = 16'h0080; wd = 16'hBEEF;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1; mc = 2'b00;
    @(negedge clk);
    total++;
    if (ram_we_n !== 1'b0) begin
      $display("FAIL rmid_in_pulse we_n=%b req=0", ram_we_n);
    end else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({ram_ce_n, ram_oe_n, ram_we_n, ram_dq_oe, busy} !== 5'b11100) begin
      $display("FAIL rmid_idle got=%b req=11100",
               {ram_ce_n, ram_oe_n, ram_we_n, ram_dq_oe, busy});
    end else pass_cnt++;
    for (int c = 0; c < 5; c++) begin
      if (done) done_n++;
      @(negedge clk);
    end
    total++;
    if (done_n != 0) begin
      $display("FAIL rmid_no_done got=%0d req=0", done_n);
    end else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int         done_n = 0;
    int         ce_n = 0;
    int         bad = 0;
    logic [8:0] done_m = '0;
    logic [8:0] busy_m = '0;
    @(posedge clk); #1;
    mc = 2'b01; addr = 16'h0040;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      done_m[c] = done;
      busy_m[c] = busy;
      if (!ram_ce_n) ce_n++;
      if (done) done_n++;
      @(posedge clk); #1;
      if (done_n >= 2) mc = 2'b00;
    end
    total++;
    if (done_m !== 9'b010001000) begin
      $display("FAIL b2b_done got=%b req=010001000", done_m);
    end else pass_cnt++;
    total++;
    if (busy_m !== 9'b001110111) begin
      $display("FAIL b2b_busy got=%b req=001110111", busy_m);
    end else pass_cnt++;
    total++;
    if (ce_n != 4 || read_data !== 16'h1234) begin
      $display("FAIL b2b_access ce=%0d rd=%h req=4/1234", ce_n, read_data);
    end else pass_cnt++;
    mc = 2'b11; addr = 16'h0040;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (busy || done || !ram_ce_n || !ram_oe_n) bad++;
    end
    mc = 2'b00;
    total++;
    if (bad != 0) begin
      $display("FAIL ctl11_idle got=%0d req=0", bad);
    end else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_sram_write();
    test_sram_read();
    test_uart_read();
    test_uart_write();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
